pba_pool_sequencer: RTL and testbench

- Controller that sequences the pool/bias/activation stage (POOL_BIAS_ACT).
- Accepts a stream of per-lane conv results plus a per-layer configuration, then builds the PBA input packet fields each cycle: if_* enables, pool_state, op mode, lane valid mask and AVG_NUM.
- Tracks pooling-window and layer boundaries, honours downstream stall, and drains the PBA pipeline before signalling layer completion.
- Sits between the conv accumulator output buffer and POOL_BIAS_ACT.

---
 rtl/pba_pool_sequencer_if.sv | 38 +++
 rtl/pba_pool_sequencer.sv | 154 +++++++++++++++
 tb/tb_pba_pool_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pba_pool_sequencer_if.sv
// Beat stream and PBA packet bundle for pba_pool_sequencer.
// master = upstream/downstream side, slave = sequencer side.
interface pba_pool_sequencer_if #(
   parameter int DATA_WID = 16,
   parameter int POOL_NUM = 4,
   parameter int CNT_WID  = 16
);
   logic                         ds_stall;
   logic                         in_valid;
   logic                         in_ready;
   logic [POOL_NUM*DATA_WID-1:0] in_data;
   logic [POOL_NUM*DATA_WID-1:0] in_bias;
   logic [POOL_NUM-1:0]          in_lane_mask;
   logic                         pk_if_pool;
   logic                         pk_if_bias;
   logic                         pk_if_act;
   logic                         pk_if_lstm;
   logic [1:0]                   pk_pool_state;
   logic                         pk_mode;
   logic [POOL_NUM-1:0]          pk_valid;
   logic [CNT_WID-1:0]           pk_avg_num;
   logic [POOL_NUM*DATA_WID-1:0] pk_data;
   logic [POOL_NUM*DATA_WID-1:0] pk_bias;

   modport master (
      output ds_stall, in_valid, in_data, in_bias, in_lane_mask,
      input  in_ready, pk_if_pool, pk_if_bias, pk_if_act, pk_if_lstm,
      input  pk_pool_state, pk_mode, pk_valid, pk_avg_num,
      input  pk_data, pk_bias
   );

   modport slave (
      input  ds_stall, in_valid, in_data, in_bias, in_lane_mask,
      output in_ready, pk_if_pool, pk_if_bias, pk_if_act, pk_if_lstm,
      output pk_pool_state, pk_mode, pk_valid, pk_avg_num,
      output pk_data, pk_bias
   );
endinterface

// File: rtl/pba_pool_sequencer.sv
// Sequencer feeding POOL_BIAS_ACT packets from the conv output stream.
// Optional PBA_SEQ_PERF_CNT_EN adds the stall_cnt performance counter.
module pba_pool_sequencer #(
   parameter int DATA_WID  = 16,
   parameter int POOL_NUM  = 4,
   parameter int CNT_WID   = 16,
   parameter int DRAIN_CYC = 40
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_start,
   input  logic               cfg_mode,
   input  logic [CNT_WID-1:0] cfg_win,
   input  logic [CNT_WID-1:0] cfg_num_win,
   input  logic               cfg_if_pool,
   input  logic               cfg_if_bias,
   input  logic               cfg_if_act,
   input  logic               cfg_if_lstm,
   pba_pool_sequencer_if.slave bus,
`ifdef PBA_SEQ_PERF_CNT_EN
   output logic [CNT_WID-1:0] stall_cnt,
`endif
   output logic               busy,
   output logic               done
);
   localparam int DW = $clog2(DRAIN_CYC + 1);
   localparam logic [1:0] INVALID = 2'd0;
   localparam logic [1:0] VALID   = 2'd1;
   localparam logic [1:0] FINISH  = 2'd2;
   localparam logic [1:0] COMPL   = 2'd3;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state;
   logic [CNT_WID-1:0] win_r;
   logic [CNT_WID-1:0] num_r;
   logic [CNT_WID-1:0] elem_cnt;
   logic [CNT_WID-1:0] win_cnt;
   logic               mode_r;
   logic               pool_r;
   logic               bias_r;
   logic               act_r;
   logic               lstm_r;
   logic [DW-1:0]      dcnt;
   logic               accept;
   logic               last_elem;
   logic               last_win;

   assign bus.in_ready = (state == RUN) && !bus.ds_stall;
   assign accept       = bus.in_valid && bus.in_ready;
   assign last_elem    = elem_cnt == win_r - CNT_WID'(1);
   assign last_win     = win_cnt == num_r - CNT_WID'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         win_r             <= '0;
         num_r             <= '0;
         elem_cnt          <= '0;
         win_cnt           <= '0;
         mode_r            <= 1'b0;
         pool_r            <= 1'b0;
         bias_r            <= 1'b0;
         act_r             <= 1'b0;
         lstm_r            <= 1'b0;
         dcnt              <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         bus.pk_if_pool    <= 1'b0;
         bus.pk_if_bias    <= 1'b0;
         bus.pk_if_act     <= 1'b0;
         bus.pk_if_lstm    <= 1'b0;
         bus.pk_pool_state <= INVALID;
         bus.pk_mode       <= 1'b0;
         bus.pk_valid      <= '0;
         bus.pk_avg_num    <= '0;
         bus.pk_data       <= '0;
         bus.pk_bias       <= '0;
`ifdef PBA_SEQ_PERF_CNT_EN
         stall_cnt         <= '0;
`endif
      end else begin
         // Packet qualifiers default to an empty slot; data/bias hold.
         done              <= 1'b0;
         bus.pk_pool_state <= INVALID;
         bus.pk_valid      <= '0;
         bus.pk_if_pool    <= 1'b0;
         bus.pk_if_bias    <= 1'b0;
         bus.pk_if_act     <= 1'b0;
         bus.pk_if_lstm    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cfg_start) begin
                  win_r    <= (cfg_win == '0) ? CNT_WID'(1) : cfg_win;
                  num_r    <= (cfg_num_win == '0) ? CNT_WID'(1) : cfg_num_win;
                  mode_r   <= cfg_mode;
                  pool_r   <= cfg_if_pool;
                  bias_r   <= cfg_if_bias;
                  act_r    <= cfg_if_act;
                  lstm_r   <= cfg_if_lstm;
                  elem_cnt <= '0;
                  win_cnt  <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
`ifdef PBA_SEQ_PERF_CNT_EN
                  stall_cnt <= '0;
`endif
               end
            end
            RUN: begin
`ifdef PBA_SEQ_PERF_CNT_EN
               if (bus.ds_stall && stall_cnt != '1)
                  stall_cnt <= stall_cnt + CNT_WID'(1);
`endif
               if (accept) begin
                  bus.pk_data    <= bus.in_data;
                  bus.pk_bias    <= bus.in_bias;
                  bus.pk_valid   <= bus.in_lane_mask;
                  bus.pk_if_pool <= pool_r;
                  bus.pk_if_bias <= bias_r;
                  bus.pk_if_act  <= act_r;
                  bus.pk_if_lstm <= lstm_r;
                  bus.pk_mode    <= mode_r;
                  bus.pk_avg_num <= mode_r ? win_r : '0;
                  if (!last_elem) begin
                     elem_cnt          <= elem_cnt + CNT_WID'(1);
                     bus.pk_pool_state <= VALID;
                  end else if (!last_win) begin
                     elem_cnt          <= '0;
                     win_cnt           <= win_cnt + CNT_WID'(1);
                     bus.pk_pool_state <= FINISH;
                  end else begin
                     elem_cnt          <= '0;
                     dcnt              <= '0;
                     bus.pk_pool_state <= COMPL;
                     state             <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (dcnt == DW'(DRAIN_CYC)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  dcnt <= dcnt + DW'(1);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pba_pool_sequencer.sv
// Self-checking bench for pba_pool_sequencer with a beat-index reference model.
// Honours PBA_SEQ_PERF_CNT_EN for the stall_cnt checks.
module tb_pba_pool_sequencer;
   localparam int DW = 16;
   localparam int PN = 4;
   localparam int CW = 16;
   localparam int DC = 40;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_start;
   logic          cfg_mode;
   logic [CW-1:0] cfg_win;
   logic [CW-1:0] cfg_num_win;
   logic          cfg_if_pool;
   logic          cfg_if_bias;
   logic          cfg_if_act;
   logic          cfg_if_lstm;
   logic          busy;
   logic          done;
`ifdef PBA_SEQ_PERF_CNT_EN
   logic [CW-1:0] stall_cnt;
`endif

   pba_pool_sequencer_if #(.DATA_WID(DW), .POOL_NUM(PN), .CNT_WID(CW)) bus ();

   pba_pool_sequencer #(
      .DATA_WID(DW), .POOL_NUM(PN), .CNT_WID(CW), .DRAIN_CYC(DC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cfg_start(cfg_start),
      .cfg_mode(cfg_mode),
      .cfg_win(cfg_win),
      .cfg_num_win(cfg_num_win),
      .cfg_if_pool(cfg_if_pool),
      .cfg_if_bias(cfg_if_bias),
      .cfg_if_act(cfg_if_act),
      .cfg_if_lstm(cfg_if_lstm),
      .bus(bus),
`ifdef PBA_SEQ_PERF_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   bit              m_run;
   int              m_k;
   int              m_w;
   int              m_n;
   bit              m_mode;
   bit [3:0]        m_if;
   logic [PN*DW-1:0] m_data;
   logic [PN*DW-1:0] m_bias;
   int              m_stall;

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_layer(bit mode, int win, int num, bit [3:0] ifs);
      cfg_start   = 1'b1;
      cfg_mode    = mode;
      cfg_win     = win[CW-1:0];
      cfg_num_win = num[CW-1:0];
      cfg_if_pool = ifs[0];
      cfg_if_bias = ifs[1];
      cfg_if_act  = ifs[2];
      cfg_if_lstm = ifs[3];
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      m_run   = 1'b1;
      m_k     = 0;
      m_w     = (win == 0) ? 1 : win;
      m_n     = (num == 0) ? 1 : num;
      m_mode  = mode;
      m_if    = ifs;
      m_stall = 0;
      chk("busy_start", busy, 1);
      @(negedge clk);
   endtask

   task automatic beat(bit v, bit st, logic [PN-1:0] mask);
      logic [PN*DW-1:0] d;
      logic [PN*DW-1:0] b;
      bit acc;
      int stv;
      d = {$urandom, $urandom};
      b = {$urandom, $urandom};
      bus.in_valid     = v;
      bus.ds_stall     = st;
      bus.in_data      = d;
      bus.in_bias      = b;
      bus.in_lane_mask = mask;
      #1;
      chk("in_ready", bus.in_ready, m_run && !st);
      acc = m_run && v && !st;
      if (m_run && st) m_stall++;
      @(posedge clk);
      #1;
      if (acc) begin
         if (m_k == m_w * m_n - 1) stv = 3;
         else if (m_k % m_w == m_w - 1) stv = 2;
         else stv = 1;
         m_k++;
         m_data = d;
         m_bias = b;
         chk("pool_state", bus.pk_pool_state, stv);
         chk("pk_valid", bus.pk_valid, mask);
         chk("pk_if", {bus.pk_if_lstm, bus.pk_if_act,
                       bus.pk_if_bias, bus.pk_if_pool}, m_if);
         chk("pk_mode", bus.pk_mode, m_mode);
         chk("avg_num", bus.pk_avg_num, m_mode ? m_w : 0);
         chk("pk_data", bus.pk_data, m_data);
         chk("pk_bias", bus.pk_bias, m_bias);
         if (stv == 3) m_run = 1'b0;
      end else begin
         chk("idle_state", bus.pk_pool_state, 0);
         chk("idle_valid", bus.pk_valid, 0);
         chk("idle_if", {bus.pk_if_lstm, bus.pk_if_act,
                         bus.pk_if_bias, bus.pk_if_pool}, 0);
         chk("hold_data", bus.pk_data, m_data);
         chk("hold_bias", bus.pk_bias, m_bias);
      end
      bus.in_valid = 1'b0;
      bus.ds_stall = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done(bit inject);
      int  n;
      bit  prev_busy;
      n = 0;
      prev_busy = 1'b1;
      bus.in_valid = 1'b1;
      while (n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 2) chk("drain_ready", bus.in_ready, 0);
         if (inject && n == 5) begin
            cfg_start = 1'b1;
            cfg_win   = 16'd7;
         end
         if (n == 6) cfg_start = 1'b0;
         if (done) break;
         prev_busy = busy;
      end
      bus.in_valid = 1'b0;
      chk("done_lat", n, DC + 1);
      chk("busy_pre", prev_busy, 1);
      chk("busy_fall", busy, 0);
`ifdef PBA_SEQ_PERF_CNT_EN
      chk("stall_hold", stall_cnt, m_stall);
`endif
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) n++;
      end
      chk("after_done", n, 0);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int cnt;
      reset            = 1'b1;
      cfg_start        = 1'b0;
      cfg_mode         = 1'b0;
      cfg_win          = '0;
      cfg_num_win      = '0;
      cfg_if_pool      = 1'b0;
      cfg_if_bias      = 1'b0;
      cfg_if_act       = 1'b0;
      cfg_if_lstm      = 1'b0;
      bus.in_valid     = 1'b0;
      bus.ds_stall     = 1'b0;
      bus.in_data      = '0;
      bus.in_bias      = '0;
      bus.in_lane_mask = '0;
      m_run  = 1'b0;
      m_data = '0;
      m_bias = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_state", bus.pk_pool_state, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_data", bus.pk_data, 0);
      reset = 1'b0;
      @(negedge clk);

      start_layer(1'b0, 2, 2, 4'b0111);
      repeat (4) beat(1'b1, 1'b0, 4'b1111);
      wait_done(1'b0);

      start_layer(1'b1, 3, 1, 4'b0011);
      beat(1'b1, 1'b0, 4'b0001);
      beat(1'b1, 1'b0, 4'b0010);
      beat(1'b1, 1'b0, 4'b0100);
      wait_done(1'b0);

      start_layer(1'b0, 4, 1, 4'b1000);
      beat(1'b1, 1'b0, 4'b1010);
      repeat (5) beat(1'b1, 1'b1, 4'b1111);
`ifdef PBA_SEQ_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, 5);
`endif
      beat(1'b1, 1'b0, 4'b0000);
      beat(1'b0, 1'b0, 4'b1111);
      beat(1'b1, 1'b0, 4'b0110);
      beat(1'b1, 1'b0, 4'b1001);
      wait_done(1'b0);

      start_layer(1'b1, 0, 0, 4'b0001);
      beat(1'b1, 1'b0, 4'b1111);
      wait_done(1'b0);

      start_layer(1'b0, 3, 2, 4'b1111);
      beat(1'b1, 1'b0, 4'b1111);
      reset = 1'b1;
      #1;
      chk("arst_state", bus.pk_pool_state, 0);
      chk("arst_data", bus.pk_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ready", bus.in_ready, 0);
      m_run  = 1'b0;
      m_data = '0;
      m_bias = '0;
      @(negedge clk);
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (done) cnt++;
      end
      chk("no_done", cnt, 0);
      @(negedge clk);
      start_layer(1'b0, 2, 1, 4'b0101);
      beat(1'b1, 1'b0, 4'b0011);
      beat(1'b1, 1'b0, 4'b1100);
      wait_done(1'b0);

      start_layer(1'b1, 2, 1, 4'b0010);
      beat(1'b1, 1'b0, 4'b1111);
      beat(1'b1, 1'b0, 4'b1111);
      wait_done(1'b1);

      for (int l = 0; l < 6; l++) begin
         start_layer(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
         for (int i = 0; i < 200 && m_run; i++)
            beat(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)));
         chk("rand_end", m_run, 0);
         wait_done(1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
